// File: rtl/vreg_store_if.sv
// Store-unit side bundle: register-file read port plus the 32-bit memory write port.
interface vreg_store_if #(
    parameter int WORD_W = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 32
);
    logic [1:0]              rd_sel;
    logic [LANES*WORD_W-1:0] rd_data;
    logic                    mem_valid;
    logic                    mem_ready;
    logic [ADDR_W-1:0]       mem_addr;
    logic [WORD_W-1:0]       mem_wdata;

    modport master (
        output rd_sel,
        input  rd_data,
        output mem_valid,
        input  mem_ready,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input  rd_sel,
        output rd_data,
        input  mem_valid,
        output mem_ready,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/vreg_store_unit.sv
// Snapshots one vector register (or the A[2]/A[3] product pair) and streams it
// to memory as 32-bit words over a valid/ready write port.
module vreg_store_unit #(
    parameter int WORD_W = 32,
    parameter int LANES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pair_mode,
    input  logic [1:0]        src_reg,
    input  logic [ADDR_W-1:0] base_addr,
    vreg_store_if.master      bus,
    output logic              busy,
    output logic              done
);
    localparam int VREG_W = LANES * WORD_W;
    localparam int CNT_W  = $clog2(2 * LANES);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CAP_LO = 3'd1,
        CAP_HI = 3'd2,
        SEND   = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Pair mode interleaves low/high halves so each 64-bit product lands little-endian.
    function automatic logic [WORD_W-1:0] word_of(input logic pm, input logic [CNT_W-1:0] k,
                                                  input logic [VREG_W-1:0] lo,
                                                  input logic [VREG_W-1:0] hi);
        logic [LANE_W-1:0] lane;
        if (pm) begin
            lane    = k[CNT_W-1:1];
            word_of = k[0] ? hi[lane*WORD_W +: WORD_W] : lo[lane*WORD_W +: WORD_W];
        end else begin
            lane    = k[LANE_W-1:0];
            word_of = lo[lane*WORD_W +: WORD_W];
        end
    endfunction

    state_t            state_r, state_s;
    logic              pair_r, pair_s;
    logic [1:0]        rd_sel_r, rd_sel_s;
    logic [VREG_W-1:0] lo_snap_r, lo_snap_s;
    logic [VREG_W-1:0] hi_snap_r, hi_snap_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              mem_valid_r, mem_valid_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [WORD_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [CNT_W-1:0]  last_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    assign bus.rd_sel    = rd_sel_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Next-state and next-value logic for every register; outputs are all registered.
    always_comb begin
        state_s     = state_r;
        pair_s      = pair_r;
        rd_sel_s    = rd_sel_r;
        lo_snap_s   = lo_snap_r;
        hi_snap_s   = hi_snap_r;
        cnt_s       = cnt_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        busy_s      = busy_r;
        done_s      = done_r;
        last_s      = pair_r ? CNT_W'(2 * LANES - 1) : CNT_W'(LANES - 1);
        cnt_inc_s   = cnt_r + CNT_W'(1);

        case (state_r)
            IDLE: begin
                if (start) begin
                    pair_s     = pair_mode;
                    mem_addr_s = {base_addr[ADDR_W-1:2], 2'b00};
                    rd_sel_s   = pair_mode ? 2'd2 : src_reg;
                    cnt_s      = {CNT_W{1'b0}};
                    busy_s     = 1'b1;
                    state_s    = CAP_LO;
                end else begin
                    state_s = IDLE;
                end
            end
            CAP_LO: begin
                lo_snap_s = bus.rd_data;
                if (pair_r) begin
                    rd_sel_s = 2'd3;
                    state_s  = CAP_HI;
                end else begin
                    // Snapshot is not yet visible, so word 0 comes straight off the read bus.
                    mem_wdata_s = bus.rd_data[WORD_W-1:0];
                    mem_valid_s = 1'b1;
                    state_s     = SEND;
                end
            end
            CAP_HI: begin
                hi_snap_s   = bus.rd_data;
                mem_wdata_s = lo_snap_r[WORD_W-1:0];
                mem_valid_s = 1'b1;
                state_s     = SEND;
            end
            SEND: begin
                if (mem_valid_r && bus.mem_ready) begin
                    if (cnt_r == last_s) begin
                        mem_valid_s = 1'b0;
                        done_s      = 1'b1;
                        state_s     = DONE;
                    end else begin
                        cnt_s       = cnt_inc_s;
                        mem_addr_s  = mem_addr_r + ADDR_W'(WORD_W / 8);
                        mem_wdata_s = word_of(pair_r, cnt_inc_s, lo_snap_r, hi_snap_r);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                done_s  = 1'b0;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                mem_valid_s = 1'b0;
                busy_s      = 1'b0;
                done_s      = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            pair_r      <= 1'b0;
            rd_sel_r    <= 2'd0;
            lo_snap_r   <= {VREG_W{1'b0}};
            hi_snap_r   <= {VREG_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mem_valid_r <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {WORD_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            pair_r      <= pair_s;
            rd_sel_r    <= rd_sel_s;
            lo_snap_r   <= lo_snap_s;
            hi_snap_r   <= hi_snap_s;
            cnt_r       <= cnt_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end
endmodule

// File: tb/tb_vreg_store_unit.sv
// Directed bench for vreg_store_unit: register-file model, write logger and
// hand-derived address/data/latency expectations.
module tb_vreg_store_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic        pair_mode;
    logic [1:0]  src_reg;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;

    logic [511:0] rf [4];
    logic [31:0]  wr_addr_q [$];
    logic [31:0]  wr_data_q [$];
    int           cyc;
    int           checks;
    int           failures;

    vreg_store_if #(.WORD_W(32), .LANES(16), .ADDR_W(32)) bus ();

    vreg_store_unit #(.WORD_W(32), .LANES(16), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pair_mode (pair_mode),
        .src_reg   (src_reg),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    assign bus.rd_data = rf[bus.rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change just after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (rst && bus.mem_valid && bus.mem_ready) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
        end
    end

    // Independent lane pattern; the few named lanes carry the hand-picked test values.
    function automatic logic [31:0] pat(input int r, input int j);
        logic [7:0] r8;
        logic [7:0] j8;
        if (r == 1 && j == 0)       pat = 32'h0000_0001;
        else if (r == 1 && j == 15) pat = 32'hFFFF_FFFF;
        else if (r == 2 && j == 0)  pat = 32'h89AB_CDEF;
        else if (r == 3 && j == 0)  pat = 32'h0123_4567;
        else begin
            r8  = 8'(r);
            j8  = 8'(j);
            pat = {8'hA0 | r8, 8'h5C, j8, 8'h3E ^ j8};
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rf();
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 16; j++)
                rf[r][j*32 +: 32] = pat(r, j);
    endtask

    // Drives one store to completion; optional stall, mid-store start and register poke.
    task automatic run_store(input logic pm, input logic [1:0] src, input logic [31:0] base,
                             input int stall_word, input int stall_len, input int mid_start_word,
                             input int poke_word, output int lat_valid, output int lat_done);
        int          t0;
        int          stall_left;
        bit          poked;
        logic [31:0] hold_addr;
        wr_addr_q.delete();
        wr_data_q.delete();
        lat_valid  = -1;
        lat_done   = -1;
        stall_left = stall_len;
        poked      = 1'b0;
        pair_mode  = pm;
        src_reg    = src;
        base_addr  = base;
        start      = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
        for (int n = 0; n < 200 && lat_done < 0; n++) begin
            if (bus.mem_valid && lat_valid < 0) lat_valid = cyc - t0;
            if (done) lat_done = cyc - t0;
            if (bus.mem_valid && wr_addr_q.size() == stall_word && stall_left > 0) begin
                bus.mem_ready = 1'b0;
                stall_left--;
                hold_addr = {base[31:2], 2'b00} + 32'(4 * stall_word);
                check("stall_valid", 64'(bus.mem_valid), 64'd1);
                check("stall_addr", 64'(bus.mem_addr), 64'(hold_addr));
                check("stall_data", 64'(bus.mem_wdata), 64'(pat(int'(src), stall_word)));
            end else begin
                bus.mem_ready = 1'b1;
            end
            start = (bus.mem_valid && wr_addr_q.size() == mid_start_word);
            if (wr_addr_q.size() == poke_word && !poked) begin
                rf[src] = ~rf[src];
                poked   = 1'b1;
            end
            if (lat_done < 0) tick();
        end
        if (lat_done < 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("busy_in_done", 64'(busy), 64'd1);
            start = 1'b1;
            tick();
            start = 1'b0;
            check("done_pulse_end", 64'(done), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input logic pm, input int src, input logic [31:0] base);
        int          n;
        logic [31:0] ea;
        logic [31:0] ed;
        n = pm ? 32 : 16;
        check({tag, "_count"}, 64'(wr_addr_q.size()), 64'(n));
        for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
            ea = {base[31:2], 2'b00} + 32'(4 * k);
            ed = pm ? pat((k % 2 == 1) ? 3 : 2, k / 2) : pat(src, k);
            check({tag, "_addr"}, 64'(wr_addr_q[k]), 64'(ea));
            check({tag, "_data"}, 64'(wr_data_q[k]), 64'(ed));
        end
    endtask

    initial begin
        int lv;
        int ld;
        int sz;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        rst           = 1'b0;
        start         = 1'b0;
        pair_mode     = 1'b0;
        src_reg       = 2'd0;
        base_addr     = 32'd0;
        bus.mem_ready = 1'b1;
        load_rf();
        tick();
        tick();
        check("rst_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_sel", 64'(bus.rd_sel), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        rst = 1'b1;
        tick();

        // 1: single store, full-speed
        run_store(1'b0, 2'd1, 32'h100, -1, 0, -1, -1, lv, ld);
        check("t1_lat_valid", 64'(lv), 64'd1);
        check("t1_lat_done", 64'(ld), 64'd17);
        check_seq("t1", 1'b0, 1, 32'h100);
        if (wr_data_q.size() == 16) begin
            check("t1_word0", 64'(wr_data_q[0]), 64'h0000_0001);
            check("t1_word15", 64'(wr_data_q[15]), 64'hFFFF_FFFF);
            check("t1_last_addr", 64'(wr_addr_q[15]), 64'h13C);
        end else begin
            check("t1_words", 64'(wr_data_q.size()), 64'd16);
        end

        // 2: pair mode, with rd_sel sequence observed by hand
        pair_mode = 1'b1;
        src_reg   = 2'd0;
        base_addr = 32'h100;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("t2_rd_sel_lo", 64'(bus.rd_sel), 64'd2);
        tick();
        check("t2_rd_sel_hi", 64'(bus.rd_sel), 64'd3);
        for (int n = 0; n < 60 && !done; n++) tick();
        check("t2_done_seen", 64'(done), 64'd1);
        tick();
        run_store(1'b1, 2'd0, 32'h100, -1, 0, -1, -1, lv, ld);
        check("t2_lat_valid", 64'(lv), 64'd2);
        check("t2_lat_done", 64'(ld), 64'd34);
        check_seq("t2", 1'b1, 0, 32'h100);
        if (wr_data_q.size() >= 2) begin
            check("t2_w100", 64'(wr_data_q[0]), 64'h89AB_CDEF);
            check("t2_w104", 64'(wr_data_q[1]), 64'h0123_4567);
        end else begin
            check("t2_words", 64'(wr_data_q.size()), 64'd32);
        end

        // 3: three-cycle backpressure on word 5
        run_store(1'b0, 2'd0, 32'h2000, 5, 3, -1, -1, lv, ld);
        check("t3_lat_done", 64'(ld), 64'd20);
        check_seq("t3", 1'b0, 0, 32'h2000);

        // 4: address wrap and unaligned base
        run_store(1'b0, 2'd3, 32'hFFFF_FFF8, -1, 0, -1, -1, lv, ld);
        check_seq("t4", 1'b0, 3, 32'hFFFF_FFF8);
        if (wr_addr_q.size() >= 3) check("t4_wrap", 64'(wr_addr_q[2]), 64'h0);
        else check("t4_words", 64'(wr_addr_q.size()), 64'd16);
        run_store(1'b0, 2'd2, 32'h103, -1, 0, -1, -1, lv, ld);
        if (wr_addr_q.size() >= 1) check("t4_align", 64'(wr_addr_q[0]), 64'h100);
        else check("t4_words_b", 64'(wr_addr_q.size()), 64'd16);

        // 5: start during SEND ignored; register write after capture not seen
        run_store(1'b0, 2'd1, 32'h400, -1, 0, 4, 2, lv, ld);
        check_seq("t5", 1'b0, 1, 32'h400);
        load_rf();
        for (int n = 0; n < 4; n++) tick();
        check("t5_no_restart", 64'(busy), 64'd0);
        check("t5_no_valid", 64'(bus.mem_valid), 64'd0);

        // 6: reset mid-store at word 7
        wr_addr_q.delete();
        wr_data_q.delete();
        pair_mode = 1'b0;
        src_reg   = 2'd0;
        base_addr = 32'h600;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 40 && !(bus.mem_valid && wr_addr_q.size() == 7); n++) tick();
        check("t6_reached_w7", 64'(wr_addr_q.size()), 64'd7);
        rst = 1'b0;
        #1;
        check("t6_valid_rst", 64'(bus.mem_valid), 64'd0);
        check("t6_busy_rst", 64'(busy), 64'd0);
        tick();
        rst = 1'b1;
        sz  = wr_addr_q.size();
        for (int n = 0; n < 6; n++) tick();
        check("t6_no_writes", 64'(wr_addr_q.size()), 64'(sz));
        check("t6_idle_valid", 64'(bus.mem_valid), 64'd0);
        run_store(1'b0, 2'd0, 32'h600, -1, 0, -1, -1, lv, ld);
        check("t6_lat_done", 64'(ld), 64'd17);
        check_seq("t6", 1'b0, 0, 32'h600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
